// File: rtl/mem_ctrl_pkg.sv
// Shared definitions for the byte-serial memory controller.
// Holds the transfer length encodings, the controller state encoding,
// the IO-select field value and a helper mapping a length code to a byte count.
package mem_ctrl_pkg;

  localparam logic [1:0] LEN_BYTE = 2'd0;
  localparam logic [1:0] LEN_HALF = 2'd1;
  localparam logic [1:0] LEN_WORD = 2'd2;

  // Address field value that routes an access to the IO space.
  localparam logic [1:0] IO_SEL = 2'b11;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_STORE = 3'd1,
    ST_LOAD  = 3'd2,
    ST_FETCH = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  // Length code 3 is illegal and behaves as a word.
  function automatic logic [2:0] len_bytes(input logic [1:0] len);
    case (len)
      LEN_BYTE: return 3'd1;
      LEN_HALF: return 3'd2;
      default:  return 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_load_extend.sv
// Load result extension: takes the assembled little-endian raw word and
// produces the 32-bit load value for the given length.
// Ports: raw (assembled bytes), len (LEN_* code), sgn (sign-extend), data (result).
module mem_load_extend
  import mem_ctrl_pkg::*;
(
  input  logic [31:0] raw,
  input  logic [1:0]  len,
  input  logic        sgn,
  output logic [31:0] data
);

  always_comb begin
    case (len)
      LEN_BYTE: data = {{24{sgn & raw[7]}}, raw[7:0]};
      LEN_HALF: data = {{16{sgn & raw[15]}}, raw[15:0]};
      default:  data = raw;
    endcase
  end

endmodule

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller between the LSB / instruction fetch clients
// and the 8-bit RAM/IO bus. Arbitrates (store > load > fetch), sequences
// little-endian multi-byte transfers and pulses per-client success flags.
// Ports:
//   clk, rst (sync, active high), rdy (global enable), jump_wrong (flush)
//   LSB side : lsb_read_signal, lsb_write_signal, requiring_length,
//              lsb_load_signed, to_mem_addr, to_mem_data, from_mem_data,
//              mem_load_success, mem_store_success
//   Fetch    : if_read_signal, if_addr, if_data, if_success
//   RAM bus  : mem_din, mem_dout, mem_a, mem_wr, io_buffer_full
// Optional feature macro IO_BUFFER_STALL_EN: stall IO stores while the UART
// buffer is full. Without it io_buffer_full is ignored.
module mem_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int IO_SEL_HI  = 17,
  parameter int IO_SEL_LO  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rdy,
  input  logic                  jump_wrong,
  input  logic                  lsb_read_signal,
  input  logic                  lsb_write_signal,
  input  logic [1:0]            requiring_length,
  input  logic                  lsb_load_signed,
  input  logic [ADDR_WIDTH-1:0] to_mem_addr,
  input  logic [31:0]           to_mem_data,
  output logic [31:0]           from_mem_data,
  output logic                  mem_load_success,
  output logic                  mem_store_success,
  input  logic                  if_read_signal,
  input  logic [ADDR_WIDTH-1:0] if_addr,
  output logic [31:0]           if_data,
  output logic                  if_success,
  input  logic [7:0]            mem_din,
  output logic [7:0]            mem_dout,
  output logic [ADDR_WIDTH-1:0] mem_a,
  output logic                  mem_wr,
  input  logic                  io_buffer_full
);

  state_t                state, state_n;
  // STORE: index of the byte on the bus. LOAD/FETCH: number of addresses issued.
  logic [2:0]            cnt, cnt_n;
  logic [ADDR_WIDTH-1:0] addr_q, addr_n, mem_a_n;
  logic [1:0]            len_q, len_n;
  logic [31:0]           data_q, data_n, raw_q, raw_n, raw_fill, ext;
  logic [31:0]           ld_data_n, if_data_n;
  logic                  sgn_q, sgn_n;
  logic [7:0]            mem_dout_n;
  logic                  wr_q, wr_n;
  logic                  st_ok_q, st_ok_n, ld_ok_n, if_ok_n;
  logic [2:0]            nbytes;
  logic [1:0]            st_idx, ld_idx;
  logic                  stall;

  assign nbytes = len_bytes(len_q);
  assign st_idx = 2'(cnt + 3'd1);
  assign ld_idx = 2'(cnt - 3'd1);

`ifdef IO_BUFFER_STALL_EN
  assign stall = (state == ST_STORE) && (mem_a[IO_SEL_HI:IO_SEL_LO] == IO_SEL) && io_buffer_full;
`else
  logic unused_io;
  assign stall     = 1'b0;
  assign unused_io = io_buffer_full;
`endif

  // The byte read back this cycle belongs to the previously issued address.
  always_comb begin
    raw_fill                = raw_q;
    raw_fill[8*ld_idx +: 8] = mem_din;
  end

  mem_load_extend u_ext (.raw(raw_fill), .len(len_q), .sgn(sgn_q), .data(ext));

  // The store pulse travels with the last byte, so it is masked while that byte stalls.
  assign mem_wr            = wr_q & rdy & ~stall;
  assign mem_store_success = st_ok_q & ~stall;

  always_comb begin
    state_n    = state;
    cnt_n      = cnt;
    addr_n     = addr_q;
    len_n      = len_q;
    data_n     = data_q;
    sgn_n      = sgn_q;
    raw_n      = raw_q;
    mem_a_n    = mem_a;
    mem_dout_n = mem_dout;
    wr_n       = wr_q;
    st_ok_n    = 1'b0;
    ld_ok_n    = 1'b0;
    if_ok_n    = 1'b0;
    ld_data_n  = from_mem_data;
    if_data_n  = if_data;
    unique case (state)
      ST_IDLE: if (!jump_wrong) begin
        if (lsb_write_signal) begin
          state_n    = ST_STORE;
          cnt_n      = 3'd0;
          addr_n     = to_mem_addr;
          len_n      = requiring_length;
          data_n     = to_mem_data;
          mem_a_n    = to_mem_addr;
          mem_dout_n = to_mem_data[7:0];
          wr_n       = 1'b1;
          st_ok_n    = (len_bytes(requiring_length) == 3'd1);
        end else if (lsb_read_signal) begin
          state_n = ST_LOAD;
          cnt_n   = 3'd1;
          addr_n  = to_mem_addr;
          len_n   = requiring_length;
          sgn_n   = lsb_load_signed;
          mem_a_n = to_mem_addr;
          wr_n    = 1'b0;
        end else if (if_read_signal) begin
          state_n = ST_FETCH;
          cnt_n   = 3'd1;
          addr_n  = if_addr;
          len_n   = LEN_WORD;
          mem_a_n = if_addr;
          wr_n    = 1'b0;
        end
      end
      // Stores ignore jump_wrong: the store is already committed.
      ST_STORE: begin
        if (stall) begin
          st_ok_n = st_ok_q;
        end else if (cnt == nbytes - 3'd1) begin
          state_n = ST_DONE;
          cnt_n   = 3'd0;
          wr_n    = 1'b0;
        end else begin
          cnt_n      = cnt + 3'd1;
          mem_a_n    = addr_q + ADDR_WIDTH'(cnt + 3'd1);
          mem_dout_n = data_q[8*st_idx +: 8];
          st_ok_n    = (cnt + 3'd2 == nbytes);
        end
      end
      ST_LOAD, ST_FETCH: begin
        if (jump_wrong) begin
          state_n = ST_IDLE;
          cnt_n   = 3'd0;
        end else begin
          raw_n = raw_fill;
          if (cnt == nbytes) begin
            state_n = ST_DONE;
            cnt_n   = 3'd0;
            if (state == ST_LOAD) begin
              ld_ok_n   = 1'b1;
              ld_data_n = ext;
            end else begin
              if_ok_n   = 1'b1;
              if_data_n = raw_fill;
            end
          end else begin
            mem_a_n = addr_q + ADDR_WIDTH'(cnt);
            cnt_n   = cnt + 3'd1;
          end
        end
      end
      // One quiet cycle so the requester can drop its level request.
      ST_DONE: begin
        state_n = ST_IDLE;
        cnt_n   = 3'd0;
      end
      default: begin
        state_n = ST_IDLE;
        cnt_n   = 3'd0;
        wr_n    = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state            <= ST_IDLE;
      cnt              <= 3'd0;
      addr_q           <= '0;
      len_q            <= LEN_BYTE;
      data_q           <= '0;
      sgn_q            <= 1'b0;
      raw_q            <= '0;
      mem_a            <= '0;
      mem_dout         <= '0;
      wr_q             <= 1'b0;
      st_ok_q          <= 1'b0;
      mem_load_success <= 1'b0;
      if_success       <= 1'b0;
      from_mem_data    <= '0;
      if_data          <= '0;
    end else if (rdy) begin
      state            <= state_n;
      cnt              <= cnt_n;
      addr_q           <= addr_n;
      len_q            <= len_n;
      data_q           <= data_n;
      sgn_q            <= sgn_n;
      raw_q            <= raw_n;
      mem_a            <= mem_a_n;
      mem_dout         <= mem_dout_n;
      wr_q             <= wr_n;
      st_ok_q          <= st_ok_n;
      mem_load_success <= ld_ok_n;
      if_success       <= if_ok_n;
      from_mem_data    <= ld_data_n;
      if_data          <= if_data_n;
    end
  end

endmodule

// File: doc/mem_ctrl.md
Name: mem_ctrl

Overview:
- Byte-serial memory controller between the core's memory clients and the 8-bit single-port RAM/IO bus.
- Upstream clients: the LSB (load/store) and instruction fetch (32-bit word fetch).
- Arbitrates between clients, sequences multi-byte little-endian transfers, returns assembled data, and pulses per-client success flags.
- Stalls IO writes while the UART buffer is full; aborts speculative reads on a mispredict flush.

Parameters:
- ADDR_WIDTH, 32, byte address width.
- IO_SEL_HI, 17, upper bit of the IO-select field.
- IO_SEL_LO, 16, lower bit of the IO-select field; an address is IO when addr[IO_SEL_HI:IO_SEL_LO]==2'b11.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous active-high reset.
- rdy  in  1  global enable; low freezes all state.
- jump_wrong  in  1  mispredict flush.
- lsb_read_signal  in  1  load request, level, held until success.
- lsb_write_signal  in  1  store request, level, held until success.
- requiring_length  in  2  transfer size: 0=byte, 1=half, 2=word.
- lsb_load_signed  in  1  sign-extend the load result.
- to_mem_addr  in  32  LSB byte address.
- to_mem_data  in  32  store data, low bytes used.
- from_mem_data  out  32  load result, extended to 32 bits.
- mem_load_success  out  1  one-cycle pulse; from_mem_data is valid in the same cycle.
- mem_store_success  out  1  one-cycle pulse.
- if_read_signal  in  1  fetch request, level.
- if_addr  in  32  fetch address.
- if_data  out  32  fetched instruction.
- if_success  out  1  one-cycle pulse.
- mem_din  in  8  RAM read data; valid the cycle after its address is presented.
- mem_dout  out  8  RAM write data.
- mem_a  out  32  RAM address.
- mem_wr  out  1  1=write, 0=read.
- io_buffer_full  in  1  UART buffer full.

Behaviour:
- Reset (rst=1 at a clk edge, taking priority over rdy and jump_wrong) clears the following:
  - state=IDLE, byte counter=0.
  - mem_wr=0, mem_a=0, mem_dout=0.
  - all success pulses 0; from_mem_data=0, if_data=0.
- Reset mid-transfer abandons the transfer silently.
- rdy=0: all registers hold, and mem_wr is driven 0 combinationally.
- States: IDLE, STORE, LOAD, FETCH, DONE.
- Arbitration in IDLE:
  - Priority is lsb_write_signal > lsb_read_signal > if_read_signal.
  - The chosen address and length are latched on entry.
  - Fetch length is fixed at 4 bytes.
  - The grant is not preempted once taken.
- STORE:
  - One byte per cycle: mem_a=addr+k, mem_dout=data[8k+7:8k], mem_wr=1, for k=0..N-1.
  - After byte N-1: mem_store_success=1 for exactly one cycle, then go to DONE.
  - Latency from grant to pulse is N cycles, with no stall.
- LOAD/FETCH:
  - Present addr+k with mem_wr=0; capture mem_din into byte k-1 one cycle later.
  - The success pulse asserts the cycle after byte N-1 is captured, so N+1 cycles from grant to pulse.
  - LOAD extension:
    - Byte: bit 7 replicated if lsb_load_signed=1, else zero-filled.
    - Half: bit 15 replicated if lsb_load_signed=1, else zero-filled.
    - Word: passed through unchanged.
  - FETCH writes if_data.
- DONE: exactly one idle cycle (mem_wr=0) so the requester can drop its level request before re-arbitration; then return to IDLE.
- Address increment is modulo 2^ADDR_WIDTH; wrap-around is allowed.
- jump_wrong=1 (rdy=1):
  - In LOAD or FETCH: abort immediately to IDLE with no success pulse; a success pulse due in that cycle is suppressed.
  - In STORE: the transfer continues to completion, because the store is already committed.
  - Requests are not granted in IDLE during the flush cycle.
- requiring_length=3 is illegal and is treated as a word.
- Simultaneous store and load requests: the store wins and the load waits.

Optional Feature:
- Macro IO_BUFFER_STALL_EN.
- Defined: in STORE, when the current byte's address is IO and io_buffer_full=1:
  - mem_wr=0, and the byte counter holds.
  - The write resumes on the first cycle in which io_buffer_full=0.
  - Latency grows by the number of stalled cycles.
- Undefined: io_buffer_full is ignored; store latency is always N.

Decomposition:
- Shared package/define header holds:
  - the length encodings (LEN_BYTE=0, LEN_HALF=1, LEN_WORD=2);
  - the state encodings;
  - the IO-select constant 2'b11.
- One natural sub-module, mem_load_extend: a combinational byte assembly and sign/zero extension unit, taking (raw 32 bits, length, signed) and producing 32 bits.

Test Plan:
- Store word at 0x00000100, data 0xDEADBEEF → mem_a 0x100..0x103 with mem_dout EF,BE,AD,DE and mem_wr=1 for 4 cycles; mem_store_success pulses in the 4th cycle.
- Signed byte load from 0x200, RAM byte 0x80 → from_mem_data=0xFFFFFF80, pulse 2 cycles after grant. Repeat with lsb_load_signed=0 → 0x00000080.
- Fetch at 0x0, RAM bytes 13,05,00,00 → if_data=0x00000513; if_success pulses 5 cycles after grant.
- Store and fetch requested in the same cycle → store completes first; fetch is granted after the DONE cycle.
- jump_wrong asserted at byte 2 of a fetch → no if_success, state IDLE the next cycle. jump_wrong during a store → mem_store_success still pulses.
- IO_BUFFER_STALL_EN defined: byte store to 0x30000 with io_buffer_full high for 3 cycles → mem_wr stays 0 for those 3 cycles, then one write, then the success pulse.
